// File: rtl/sample_capture_buf.sv
// Capture buffer that fills DEPTH signed samples, asks a downstream scanner to read them, and re-arms when the scan is done.
// Latency: o_rdata is valid one cycle after i_rden. There is no backpressure: samples offered in START or BUSY are dropped.
// Build option SAMPLE_CAPTURE_DROP_CNT_EN adds the saturating o_drop_cnt output.
module sample_capture_buf #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clr,
  input  logic                       i_wr_valid,
  input  logic signed [WIDTH-1:0]    i_wr_data,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_start,
  input  logic                       i_done,
  input  logic                       i_rden,
  input  logic [$clog2(DEPTH)-1:0]   i_addr,
  output logic signed [WIDTH-1:0]    o_rdata
`ifdef SAMPLE_CAPTURE_DROP_CNT_EN
  ,
  output logic [7:0]                 o_drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [AW-1:0]           wptr;
  logic                    done_q;
  logic                    done_rise;
  logic                    wr_en;
  logic signed [WIDTH-1:0] mem [DEPTH];

  // A clear in the same cycle as a sample discards that sample.
  assign wr_en     = (state == FILL) && i_wr_valid && !i_clr;
  assign done_rise = i_done && !done_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (i_clr) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (wr_en && (wptr == AW'(DEPTH - 1))) state_nxt = START;
        START:   state_nxt = BUSY;
        BUSY:    if (done_rise) state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  always_comb begin
    o_start = 1'b0;
    o_full  = 1'b1;
    o_level = LW'(DEPTH);
    case (state)
      FILL: begin
        o_full  = 1'b0;
        o_level = {1'b0, wptr};
      end
      START:   o_start = 1'b1;
      default: ;
    endcase
  end

  // wptr wraps to 0 on the last write, so the next capture starts at address 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr   <= '0;
      done_q <= 1'b0;
    end else if (i_clr) begin
      wptr   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= i_done;
      if (wr_en) wptr <= wptr + AW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wptr] <= i_wr_data;
  end

  // Read-first: a same-address write in this cycle lands after the read sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rdata <= '0;
    end else if (i_rden) begin
      o_rdata <= mem[i_addr];
    end
  end

`ifdef SAMPLE_CAPTURE_DROP_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_drop_cnt <= 8'd0;
    end else if (i_clr) begin
      o_drop_cnt <= 8'd0;
    end else if (i_wr_valid && (state != FILL) && (o_drop_cnt != 8'hFF)) begin
      o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/sample_capture_buf.md
SAMPLE_CAPTURE_BUF -- requirements
Module: sample_capture_buf

Interface
REQ-001 Parameter DEPTH, default 128: number of sample entries; power of two, at least 4.
REQ-002 Parameter WIDTH, default 8: signed sample width in bits.
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 i_clr  input  1  synchronous abort: discard the capture and return to FILL.
REQ-006 i_wr_valid  input  1  sample strobe from the producer; there is no backpressure.
REQ-007 i_wr_data  input  WIDTH  signed sample written when accepted.
REQ-008 o_full  output  1  high whenever state is not FILL; samples are not accepted while high.
REQ-009 o_level  output  $clog2(DEPTH)+1  number of stored samples in the current capture.
REQ-010 o_start  output  1  single-cycle pulse requesting a downstream scan of the buffer.
REQ-011 i_done  input  1  downstream scan-complete level; the buffer acts on its rising edge only.
REQ-012 i_rden  input  1  read enable from the downstream scanner.
REQ-013 i_addr  input  $clog2(DEPTH)  read address.
REQ-014 o_rdata  output  WIDTH  signed registered read data.
REQ-015 o_drop_cnt  output  8  dropped-sample count; present only when the macro of REQ-034 is defined.

Function
REQ-016 Storage SHALL be a DEPTH x WIDTH array with one write port and one synchronous read port.
REQ-017 The FSM SHALL have exactly three states: FILL, START and BUSY.
REQ-018 In FILL, i_wr_valid=1 SHALL write i_wr_data at the write pointer (wptr) and increment wptr.
REQ-019 The write of entry DEPTH-1 SHALL move the FSM to START on the same edge, and wptr SHALL wrap to 0.
REQ-020 START SHALL last exactly one cycle with o_start=1, then move to BUSY; o_start SHALL be 0 in every other state.
REQ-021 BUSY SHALL move to FILL on the first cycle where i_done=1 and the registered i_done was 0.
REQ-022 A high i_done present on entry to BUSY SHALL be ignored until it has been seen low.
REQ-023 i_wr_valid in START or BUSY SHALL be ignored and SHALL NOT change the memory or wptr.
REQ-024 o_level SHALL equal wptr in FILL and DEPTH in START and BUSY.
REQ-025 i_rden=1 SHALL load o_rdata with mem[i_addr] on the next edge, in any state.
REQ-026 o_rdata SHALL hold its value while i_rden=0, so data remains valid until the next read.
REQ-027 A read and a write to the same address in the same cycle SHALL return the old contents (read-first).
REQ-028 i_clr=1 SHALL, on the next edge, force FILL, wptr=0 and the registered i_done to 0, with priority over every other event.
REQ-029 i_clr together with i_wr_valid in FILL SHALL discard the sample.
REQ-030 i_clr SHALL NOT alter memory contents or o_rdata.

Reset
REQ-031 While i_rst_n=0, the block SHALL hold state=FILL, wptr=0, o_start=0, o_full=0, o_level=0, o_rdata=0, registered i_done=0 and o_drop_cnt=0.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 Reset asserted mid-capture or mid-scan SHALL abandon that operation; the first accepted sample after release SHALL go to address 0.

Configuration
REQ-034 With SAMPLE_CAPTURE_DROP_CNT_EN defined, o_drop_cnt SHALL increment on each cycle with i_wr_valid=1 in START or BUSY.
REQ-035 o_drop_cnt SHALL saturate at 255, and SHALL be cleared to 0 by i_clr or by reset.
REQ-036 Without SAMPLE_CAPTURE_DROP_CNT_EN, the o_drop_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-037 Fill test: DEPTH=128; write 0,1,...,127 on consecutive cycles -> o_start pulses once on the cycle after the 128th write, then o_full=1 and o_level=128.
REQ-038 Read test: in BUSY, i_rden=1 with i_addr=5 -> o_rdata=5 on the next cycle, and it holds 5 while i_rden=0.
REQ-039 Drop test (macro on): ten i_wr_valid pulses in BUSY -> memory unchanged and o_drop_cnt=10; after 300 such pulses -> o_drop_cnt=255.
REQ-040 Done handshake: i_done already high on BUSY entry -> FSM stays in BUSY; i_done low then high -> FILL on the next edge with o_level=0; the next capture starts at address 0.
REQ-041 Abort test: i_clr after 40 writes -> o_level=0 and o_full=0; a following write lands at address 0 (read back -> value correct).
REQ-042 Reset test: assert i_rst_n=0 in BUSY -> all outputs at their REQ-031 values immediately (asynchronously), FSM in FILL after release.
